// File: rtl/pipe_pkg.sv
// Shared constants, stage record type and destination-match helper for the
// EX->WB pipeline register chain.
package pipe_pkg;

  localparam int DATA_W_DEF = 37;
  localparam int DEST_W_DEF = 3;
  localparam int DEPTH_MAX  = 8;
  // Widest destination index the match helper accepts; callers zero-extend.
  localparam int DEST_W_MAX = 16;

  typedef struct packed {
    logic                  valid;
    logic                  load;
    logic [DEST_W_DEF-1:0] dest;
    logic [DATA_W_DEF-1:0] payload;
  } stage_t;

  // Register 0 is hardwired to zero, so it can never be a hazard source.
  function automatic logic dest_match(input logic                  valid,
                                      input logic [DEST_W_MAX-1:0] dest,
                                      input logic [DEST_W_MAX-1:0] src);
    return valid && (dest == src) && (src != '0);
  endfunction

endpackage

// File: rtl/pipe_stage_chain_reg.sv
// One pipeline stage: holds on freeze, kill forces valid low while the
// payload fields still follow the normal hold/load path.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEST_W = DEST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              kill,
  input  logic              d_valid,
  input  logic              d_load,
  input  logic [DEST_W-1:0] d_dest,
  input  logic [DATA_W-1:0] d_payload,
  output logic              q_valid,
  output logic              q_load,
  output logic [DEST_W-1:0] q_dest,
  output logic [DATA_W-1:0] q_payload
);

  logic              valid_q, valid_d;
  logic              load_q, load_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] payload_q, payload_d;

  always_comb begin
    valid_d   = freeze ? valid_q   : d_valid;
    load_d    = freeze ? load_q    : d_load;
    dest_d    = freeze ? dest_q    : d_dest;
    payload_d = freeze ? payload_q : d_payload;
    if (kill) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      load_q    <= 1'b0;
      dest_q    <= '0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      load_q    <= load_d;
      dest_q    <= dest_d;
      payload_q <= payload_d;
    end
  end

  assign q_valid   = valid_q;
  assign q_load    = load_q;
  assign q_dest    = dest_q;
  assign q_payload = payload_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage EX->WB register chain with freeze, partial flush and hazard
// match outputs. Define PIPE_CHAIN_STALL_CNT_EN to add the stall_cnt output.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEST_W      = DEST_W_DEF,
  parameter int DEPTH       = 1,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_payload,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_load,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_payload,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_load,
`ifdef PIPE_CHAIN_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  input  logic [DEST_W-1:0] src_a,
  input  logic [DEST_W-1:0] src_b,
  output logic              hit_a,
  output logic              hit_b,
  output logic [2:0]        hit_a_idx,
  output logic [2:0]        hit_b_idx,
  output logic              load_stall
);

  if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("pipe_stage_chain: DEPTH out of range");
  end
  if (FLUSH_DEPTH < 0 || FLUSH_DEPTH > DEPTH) begin : g_bad_flush
    $error("pipe_stage_chain: FLUSH_DEPTH out of range");
  end
  if (DEST_W > DEST_W_MAX) begin : g_bad_dest
    $error("pipe_stage_chain: DEST_W too wide");
  end

  logic              vld [DEPTH];
  logic              ld  [DEPTH];
  logic [DEST_W-1:0] dst [DEPTH];
  logic [DATA_W-1:0] pay [DEPTH];
  logic              kill [DEPTH];
  logic [DEPTH-1:0]  match_a, match_b;
  logic [DEST_W_MAX-1:0] src_a_ext, src_b_ext;

  always_comb begin
    src_a_ext = '0;
    src_b_ext = '0;
    src_a_ext[DEST_W-1:0] = src_a;
    src_b_ext[DEST_W-1:0] = src_b;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [DEST_W_MAX-1:0] dest_ext;

    if (k < FLUSH_DEPTH) begin : g_kill
      assign kill[k] = flush;
    end else begin : g_keep
      assign kill[k] = 1'b0;
    end

    if (k == 0) begin : g_head
      pipe_stage_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W)) u_reg (
        .clk(clk), .rst(rst), .freeze(freeze), .kill(kill[k]),
        .d_valid(in_valid), .d_load(in_load), .d_dest(in_dest), .d_payload(in_payload),
        .q_valid(vld[k]), .q_load(ld[k]), .q_dest(dst[k]), .q_payload(pay[k])
      );
    end else begin : g_body
      pipe_stage_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W)) u_reg (
        .clk(clk), .rst(rst), .freeze(freeze), .kill(kill[k]),
        .d_valid(vld[k-1]), .d_load(ld[k-1]), .d_dest(dst[k-1]), .d_payload(pay[k-1]),
        .q_valid(vld[k]), .q_load(ld[k]), .q_dest(dst[k]), .q_payload(pay[k])
      );
    end

    always_comb begin
      dest_ext = '0;
      dest_ext[DEST_W-1:0] = dst[k];
    end

    assign match_a[k] = dest_match(vld[k], dest_ext, src_a_ext);
    assign match_b[k] = dest_match(vld[k], dest_ext, src_b_ext);
  end

  // Scan oldest to youngest so the youngest (lowest index) match wins.
  always_comb begin
    hit_a     = 1'b0;
    hit_b     = 1'b0;
    hit_a_idx = '0;
    hit_b_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_a[k]) begin
        hit_a     = 1'b1;
        hit_a_idx = 3'(k);
      end
      if (match_b[k]) begin
        hit_b     = 1'b1;
        hit_b_idx = 3'(k);
      end
    end
  end

  assign load_stall  = ld[0] & (match_a[0] | match_b[0]);

  assign out_valid   = vld[DEPTH-1];
  assign out_payload = pay[DEPTH-1];
  assign out_dest    = dst[DEPTH-1];
  assign out_load    = ld[DEPTH-1];

`ifdef PIPE_CHAIN_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (freeze && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (DEPTH=3, FLUSH_DEPTH=2): vector
// tables, hand sequences and an output scoreboard.
module tb_pipe_stage_chain;

  localparam int DATA_W = 37;
  localparam int DEST_W = 3;

  logic              clk, rst, freeze, flush;
  logic              in_valid, in_load;
  logic [DATA_W-1:0] in_payload;
  logic [DEST_W-1:0] in_dest;
  logic              out_valid, out_load;
  logic [DATA_W-1:0] out_payload;
  logic [DEST_W-1:0] out_dest;
  logic [DEST_W-1:0] src_a, src_b;
  logic              hit_a, hit_b, load_stall;
  logic [2:0]        hit_a_idx, hit_b_idx;
`ifdef PIPE_CHAIN_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  pipe_stage_chain #(.DATA_W(DATA_W), .DEST_W(DEST_W), .DEPTH(3), .FLUSH_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload), .in_dest(in_dest), .in_load(in_load),
    .out_valid(out_valid), .out_payload(out_payload), .out_dest(out_dest), .out_load(out_load),
`ifdef PIPE_CHAIN_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .src_a(src_a), .src_b(src_b), .hit_a(hit_a), .hit_b(hit_b),
    .hit_a_idx(hit_a_idx), .hit_b_idx(hit_b_idx), .load_stall(load_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] p;
    logic [DEST_W-1:0] d;
    logic              ld;
  } exp_t;

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] p;
    logic [DEST_W-1:0] d;
    logic              ld;
    logic              frz;
    logic              ev;
    logic [DATA_W-1:0] ep;
  } vec_t;

  typedef struct {
    logic [DEST_W-1:0] sa, sb;
    logic              ha;
    logic [2:0]        ia;
    logic              hb;
    logic [2:0]        ib;
    logic              ls;
  } hz_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic step();
    if (!rst && !freeze && !flush && in_valid)
      exp_q.push_back('{p: in_payload, d: in_dest, ld: in_load});
    @(posedge clk);
    #1;
  endtask

  // A slot leaves the chain on an edge where out_valid is set and freeze is low.
  always @(negedge clk) begin
    if (out_valid && !freeze && !rst) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_output", 64'(out_payload), 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_payload", 64'(out_payload), 64'(e.p));
        check("sb_dest", 64'(out_dest), 64'(e.d));
        check("sb_load", 64'(out_load), 64'(e.ld));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl[13];
  hz_t  hz[4];

  initial begin
    tbl[0]  = '{1'b1, 37'h1,  3'd1, 1'b0, 1'b0, 1'b0, 37'h0};
    tbl[1]  = '{1'b1, 37'h2,  3'd2, 1'b1, 1'b0, 1'b0, 37'h0};
    tbl[2]  = '{1'b1, 37'h3,  3'd3, 1'b0, 1'b0, 1'b1, 37'h1};
    tbl[3]  = '{1'b0, 37'h0,  3'd0, 1'b0, 1'b0, 1'b1, 37'h2};
    tbl[4]  = '{1'b0, 37'h0,  3'd0, 1'b0, 1'b0, 1'b1, 37'h3};
    tbl[5]  = '{1'b1, 37'h10, 3'd5, 1'b0, 1'b0, 1'b0, 37'h0};
    tbl[6]  = '{1'b1, 37'h11, 3'd6, 1'b1, 1'b0, 1'b0, 37'h0};
    tbl[7]  = '{1'b1, 37'h12, 3'd7, 1'b0, 1'b1, 1'b0, 37'h0};
    tbl[8]  = '{1'b1, 37'h12, 3'd7, 1'b0, 1'b1, 1'b0, 37'h0};
    tbl[9]  = '{1'b1, 37'h12, 3'd7, 1'b0, 1'b0, 1'b1, 37'h10};
    tbl[10] = '{1'b0, 37'h0,  3'd0, 1'b0, 1'b0, 1'b1, 37'h11};
    tbl[11] = '{1'b0, 37'h0,  3'd0, 1'b0, 1'b0, 1'b1, 37'h12};
    tbl[12] = '{1'b0, 37'h0,  3'd0, 1'b0, 1'b0, 1'b0, 37'h0};

    // Chain state for these: s0 dest4 load, s1 dest0, s2 dest4.
    hz[0] = '{3'd4, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b1};
    hz[1] = '{3'd0, 3'd4, 1'b0, 3'd0, 1'b1, 3'd0, 1'b1};
    hz[2] = '{3'd5, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0};
    hz[3] = '{3'd4, 3'd4, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1};

    rst = 1'b1; freeze = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_payload = 37'h55; in_dest = 3'd5; in_load = 1'b1;
    src_a = 3'd5; src_b = 3'd0;

    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_payload", 64'(out_payload), 64'd0);
      check("rst_out_dest", 64'(out_dest), 64'd0);
      check("rst_hit_a", 64'(hit_a), 64'd0);
      check("rst_load_stall", 64'(load_stall), 64'd0);
    end
`ifdef PIPE_CHAIN_STALL_CNT_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    rst = 1'b0;
    in_valid = 1'b1; in_payload = 37'hA1; in_dest = 3'd2; in_load = 1'b0;
    step();
    in_valid = 1'b0;
    check("lat_cycle1_valid", 64'(out_valid), 64'd0);
    step();
    check("lat_cycle2_valid", 64'(out_valid), 64'd0);
    step();
    check("lat_cycle3_valid", 64'(out_valid), 64'd1);
    check("lat_cycle3_payload", 64'(out_payload), 64'hA1);

    for (int i = 0; i < 13; i++) begin
      in_valid = tbl[i].v; in_payload = tbl[i].p; in_dest = tbl[i].d;
      in_load = tbl[i].ld; freeze = tbl[i].frz;
      step();
      check($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      if (tbl[i].ev)
        check($sformatf("tbl%0d_out_payload", i), 64'(out_payload), 64'(tbl[i].ep));
    end
    freeze = 1'b0;
`ifdef PIPE_CHAIN_STALL_CNT_EN
    check("freeze_stall_cnt", 64'(stall_cnt), 64'd2);
`endif

    in_valid = 1'b1; in_payload = 37'h20; in_dest = 3'd4; in_load = 1'b0;
    step();
    in_payload = 37'h21; in_dest = 3'd0; in_load = 1'b0;
    step();
    in_payload = 37'h22; in_dest = 3'd4; in_load = 1'b1;
    step();
    in_valid = 1'b0; freeze = 1'b1;
    check("fill_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      src_a = hz[i].sa; src_b = hz[i].sb;
      #1;
      check($sformatf("hz%0d_hit_a", i), 64'(hit_a), 64'(hz[i].ha));
      check($sformatf("hz%0d_hit_a_idx", i), 64'(hit_a_idx), 64'(hz[i].ia));
      check($sformatf("hz%0d_hit_b", i), 64'(hit_b), 64'(hz[i].hb));
      check($sformatf("hz%0d_hit_b_idx", i), 64'(hit_b_idx), 64'(hz[i].ib));
      check($sformatf("hz%0d_load_stall", i), 64'(load_stall), 64'(hz[i].ls));
    end

    // Flush with freeze drops the two youngest slots; stage 2 stays valid.
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    flush = 1'b1;
    src_a = 3'd4; src_b = 3'd0;
    step();
    check("flush_out_valid", 64'(out_valid), 64'd1);
    check("flush_out_payload", 64'(out_payload), 64'h20);
    check("flush_out_dest", 64'(out_dest), 64'd4);
    check("flush_hit_a", 64'(hit_a), 64'd1);
    check("flush_hit_a_idx", 64'(hit_a_idx), 64'd2);
    check("flush_load_stall", 64'(load_stall), 64'd0);
`ifdef PIPE_CHAIN_STALL_CNT_EN
    check("flush_stall_cnt", 64'(stall_cnt), 64'd3);
`endif
    flush = 1'b0; freeze = 1'b0;
    step();
    check("bubble1_out_valid", 64'(out_valid), 64'd0);
    step();
    check("bubble2_out_valid", 64'(out_valid), 64'd0);
    check("bubble2_hit_a", 64'(hit_a), 64'd0);
    step();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
Parametrised successor to the single-stage MEM pipeline register. It is a DEPTH-stage chain of payload/dest/load registers with a per-stage valid bit, a global freeze, and a partial flush. It also exposes combinational destination-match outputs, which the hazard unit uses for forwarding selection and load-use stall detection. It sits between the EX and WB sides of the MIPS pipeline and replaces the hand-written per-stage registers.

Parameters:
DATA_W, 37, payload width (ALU result plus carried fields)
DEST_W, 3, destination register index width
DEPTH, 1, number of register stages; legal range 1..8
FLUSH_DEPTH, 1, number of youngest stages (0..FLUSH_DEPTH-1) cleared by flush; legal range 0..DEPTH

Ports:
clk  in  1  clock
rst  in  1  reset
freeze  in  1  hold every stage (stall)
flush  in  1  invalidate the youngest FLUSH_DEPTH stages
in_valid  in  1  incoming slot holds a real instruction
in_payload  in  DATA_W  incoming payload
in_dest  in  DEST_W  incoming destination register
in_load  in  1  incoming instruction is a load
out_valid  out  1  stage DEPTH-1 valid
out_payload  out  DATA_W  stage DEPTH-1 payload
out_dest  out  DEST_W  stage DEPTH-1 destination
out_load  out  1  stage DEPTH-1 load flag
src_a  in  DEST_W  hazard query operand A
src_b  in  DEST_W  hazard query operand B
hit_a  out  1  operand A matches a valid stage
hit_b  out  1  operand B matches a valid stage
hit_a_idx  out  3  youngest matching stage for A
hit_b_idx  out  3  youngest matching stage for B
load_stall  out  1  load-use hazard on stage 0

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset: every stage's valid, payload, dest and load are cleared to 0. All outputs therefore read 0 after reset. rst overrides freeze and flush.
- Latency: DEPTH cycles from input to out_* when freeze stays low.
- Normal edge (freeze=0, flush=0): stage 0 loads the in_* fields. Each stage k>0 loads from stage k-1.
- freeze=1, flush=0: all stages hold, including valid.
- flush=1:
  - Stages 0..FLUSH_DEPTH-1 get valid=0 at the edge.
  - Their payload, dest and load still take the value they would otherwise have loaded (held if freeze=1, shifted if freeze=0). Only valid is forced.
  - Stages at or above FLUSH_DEPTH behave per freeze.
  - With freeze=0, the flushed bubble advances normally on later cycles.
- Invalid slots never produce a hit or load_stall and are never consumed downstream. out_valid is authoritative.
- Hazard compare (combinational from registered state only; no in_* dependency):
  - Stage k matches src if valid[k]=1, dest[k]==src, and src!=0. Register 0 is never a hazard.
  - hit_x = OR over stages of match.
  - hit_x_idx = lowest matching k. Reads 0 when no hit.
  - load_stall = valid[0] & load[0] & (match0(src_a) | match0(src_b)).
- Freeze does not mask the hazard outputs.
- DEPTH=1, FLUSH_DEPTH=0 is functionally the legacy MEM register plus valid and sync reset.

Optional Feature:
PIPE_CHAIN_STALL_CNT_EN.
- Defined: adds output stall_cnt (32 bits). It increments on every edge where freeze=1 and rst=0, saturates at all-ones, and clears on rst.
- Undefined: the port and the counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - DEST_W_DEF, DATA_W_DEF and DEPTH_MAX=8 constants.
  - typedef stage_t (valid, load, dest, payload).
  - function dest_match(valid, dest, src).
- One natural sub-module, pipe_stage_reg: a single stage_t register with a freeze hold and a kill input driving valid. pipe_stage_chain instantiates it DEPTH times via generate, with kill tied to flush for k<FLUSH_DEPTH.

Test Plan:
- Reset: DEPTH=3. Drive in_valid=1, dest=5 while rst=1 for 2 cycles -> all out_* and hit_* read 0. Release rst -> first output appears 3 cycles later.
- Streaming: DEPTH=3, payload 0x1,0x2,0x3 on consecutive cycles -> out_payload 0x1,0x2,0x3 on cycles 3,4,5, with out_valid high.
- Freeze: freeze=1 for 2 cycles mid-stream -> every stage holds and the output sequence is delayed by exactly 2 cycles. With the macro defined, stall_cnt=2.
- Flush+freeze: DEPTH=3, FLUSH_DEPTH=2, all stages valid, flush=1 and freeze=1 together -> valid[0]=valid[1]=0, stage 2 held valid. A later freeze=0 shifts the bubbles out with out_valid=0 for 2 cycles.
- Hazards:
  - Stage0 dest=4 load=1, stage2 dest=4, src_a=4 -> hit_a=1, hit_a_idx=0, load_stall=1.
  - src_a=0 with dest=0 present -> hit_a=0.
  - Stage 0 invalid -> hit_a_idx=2, load_stall=0.
